tiled_gemm_controller: RTL and testbench
========================================

Name: tiled_gemm_controller

Overview:
- Parametrised successor of the single-tile global controller, sequencing a full tiled GEMM on the systolic array.
- Walks an N-tile (output column) × K-tile (reduction) loop nest. For each (n,k) it runs weight DMA, weight load, input streaming, and drain.
- Drain is issued only after the last K tile of each N tile.
- Sits between the host AXI-Lite register block and the weight/input buffers and systolic core.

Parameters:
- CNT_W, 32, width of sequence and phase counters.
- TILE_W, 16, width of tile-count config and tile indices.
- DMA_CYCLES, 27, cycles ctrl_weight_dma_req is held per weight tile.
- LOAD_CYCLES, 12, i_weight_valid beats required per weight load.
- LATENCY, 28, drain cycles (array pipeline depth).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- ap_start  in  1  start pulse; sampled only in IDLE
- ap_abort  in  1  abandon operation; return to IDLE
- cfg_seq_len  in  CNT_W  input rows per tile
- cfg_n_tiles  in  TILE_W  N-tile count
- cfg_k_tiles  in  TILE_W  K-tile count
- ap_done  out  1  one-cycle completion pulse
- ap_idle  out  1  high in IDLE
- state_dbg  out  3  current state encoding
- ctrl_weight_dma_req  out  1  request weight DMA into buffer
- i_weight_valid  in  1  weight buffer beat valid
- ctrl_weight_load_en  out  1  buffer → array weight shift
- i_input_valid  in  1  input buffer beat valid (post-gearbox)
- ctrl_input_stream_en  out  1  input buffer read request
- ctrl_acc_clear  out  1  high during COMPUTE when k_idx==0
- ctrl_acc_last  out  1  high during COMPUTE when k_idx==cfg_k_tiles-1
- ctrl_drain_en  out  1  drain array
- tile_n_idx  out  TILE_W  current N index
- tile_k_idx  out  TILE_W  current K index

Behaviour:
- States and encodings: IDLE=0, DMA_W=1, LOAD_W=2, COMPUTE=3, DRAIN=4, DONE=5.
- All ctrl_*, ap_idle, ap_done and state_dbg are combinational decodes of the registered state. Each is asserted exactly during the cycles the FSM is in its state.
- Reset (rst_n low at a posedge, any state including mid-operation):
  - state=IDLE; all counters, indices and latched config cleared to 0.
  - All outputs 0 except ap_idle=1.
- IDLE:
  - ap_start=1 latches cfg_* into shadow registers and clears n_idx, k_idx and the phase counter.
  - Normal transition is to DMA_W.
  - If any latched cfg is 0, transition is to DONE instead, with no ctrl_* ever asserted.
- DMA_W:
  - Counter runs 0..DMA_CYCLES-1, one per cycle.
  - Transition to LOAD_W after exactly DMA_CYCLES cycles.
- LOAD_W:
  - Counter increments only on i_weight_valid.
  - The cycle holding the LOAD_CYCLES-th valid beat is the last LOAD_W cycle; next state is COMPUTE.
  - With i_weight_valid=0 the FSM stalls indefinitely.
- COMPUTE:
  - Counter increments only on i_input_valid.
  - The cycle holding the cfg_seq_len-th valid beat is the last COMPUTE cycle.
  - Exit is DMA_W with k_idx+1 if k_idx<k_tiles-1; otherwise DRAIN.
- DRAIN:
  - Runs exactly LATENCY cycles.
  - Then, if n_idx<n_tiles-1: n_idx+1, k_idx=0, go to DMA_W. Otherwise go to DONE.
- DONE: one cycle, ap_done=1, then IDLE.
- Phase counter clears on every state transition.
- ap_start outside IDLE is ignored; latched cfg is immune to cfg_* changes mid-run.
- ap_abort:
  - Takes priority over all transitions except reset.
  - Next state is IDLE with no ap_done; indices are cleared.
  - ap_abort in IDLE has no effect, and it overrides a simultaneous ap_start.
- Comparisons use full-width latched values; no wrap:
  - cfg_seq_len=2^CNT_W-1 is legal.
  - n_tiles/k_tiles=2^TILE_W-1 is legal.

Decomposition:
- Package gemm_ctrl_pkg holds:
  - state localparams (IDLE..DONE);
  - default DMA_CYCLES, LOAD_CYCLES and LATENCY constants;
  - state_dbg width.
- Sub-module tile_loop_counter handles nested n/k index update. Its inputs are clear, step_k, step_n, n_max and k_max; its outputs are the indices plus the k_last and n_last flags.

Test Plan:
- N=1,K=1,seq=4, both valids tied high, ap_start at cycle 0 → expected timeline:
  - DMA_W cycles 1–27;
  - LOAD_W 28–39;
  - COMPUTE 40–43, with acc_clear and acc_last both high;
  - DRAIN 44–71;
  - ap_done only at cycle 72; ap_idle at 73.
- N=2,K=3,seq=2, valids high → expected:
  - 6 DMA_W/LOAD_W/COMPUTE sequences;
  - exactly 2 DRAIN windows of 28 cycles;
  - acc_clear on k=0 only, acc_last on k=2 only;
  - tile_n_idx/tile_k_idx follow (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
- N=1,K=1,seq=8, i_input_valid toggling 1,0,1,0… → COMPUTE lasts 15 cycles and ctrl_input_stream_en is continuously high; i_weight_valid held low 5 cycles mid-LOAD_W → LOAD_W extends to 17 cycles.
- cfg_k_tiles=0 with ap_start → DONE the next cycle, ap_done for 1 cycle, no ctrl_* ever asserted.
- ap_abort during COMPUTE of tile (1,0) → IDLE next cycle, no ap_done, indices 0; a subsequent ap_start runs cleanly.
- rst_n low for 1 cycle during DRAIN → next cycle state_dbg=0, ap_idle=1, all ctrl_* 0; cfg_* changed mid-run produces no effect on the in-flight tile counts.

Source files
------------

// File: rtl/gemm_ctrl_pkg.sv
// Shared constants for the tiled GEMM controller: state encodings and
// default phase lengths of the weight/drain sequencing.
package gemm_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_DMA_W   = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOAD_W  = 3'd2;
    localparam logic [STATE_W-1:0] ST_COMPUTE = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN   = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;

    localparam int DEF_DMA_CYCLES  = 27;
    localparam int DEF_LOAD_CYCLES = 12;
    localparam int DEF_LATENCY     = 28;

endpackage

// File: rtl/tile_loop_counter.sv
// Nested N/K tile index counter; k resets to zero whenever n advances.
module tile_loop_counter #(
    parameter int TILE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step_k,
    input  logic              step_n,
    input  logic [TILE_W-1:0] n_max,
    input  logic [TILE_W-1:0] k_max,
    output logic [TILE_W-1:0] n_idx,
    output logic [TILE_W-1:0] k_idx,
    output logic              k_last,
    output logic              n_last
);

    localparam logic [TILE_W-1:0] ONE = {{(TILE_W-1){1'b0}}, 1'b1};

    logic [TILE_W-1:0] n_idx_r;
    logic [TILE_W-1:0] k_idx_r;

    // Index registers: clear wins over stepping, an n step also rewinds k.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_idx_r <= {TILE_W{1'b0}};
            k_idx_r <= {TILE_W{1'b0}};
        end else if (clear) begin
            n_idx_r <= {TILE_W{1'b0}};
            k_idx_r <= {TILE_W{1'b0}};
        end else if (step_n) begin
            n_idx_r <= n_idx_r + ONE;
            k_idx_r <= {TILE_W{1'b0}};
        end else if (step_k) begin
            k_idx_r <= k_idx_r + ONE;
        end else begin
            n_idx_r <= n_idx_r;
            k_idx_r <= k_idx_r;
        end
    end

    // Last-tile flags are only consulted once a nonzero count is latched.
    always_comb begin
        k_last = (k_idx_r == (k_max - ONE));
        n_last = (n_idx_r == (n_max - ONE));
    end

    assign n_idx = n_idx_r;
    assign k_idx = k_idx_r;

endmodule

// File: rtl/tiled_gemm_controller.sv
// Sequences a tiled GEMM (N output tiles x K reduction tiles) through weight
// DMA, weight load, input streaming and a per-N-tile array drain.
module tiled_gemm_controller
    import gemm_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TILE_W      = 16,
    parameter int DMA_CYCLES  = DEF_DMA_CYCLES,
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ap_start,
    input  logic               ap_abort,
    input  logic [CNT_W-1:0]   cfg_seq_len,
    input  logic [TILE_W-1:0]  cfg_n_tiles,
    input  logic [TILE_W-1:0]  cfg_k_tiles,
    output logic               ap_done,
    output logic               ap_idle,
    output logic [STATE_W-1:0] state_dbg,
    output logic               ctrl_weight_dma_req,
    input  logic               i_weight_valid,
    output logic               ctrl_weight_load_en,
    input  logic               i_input_valid,
    output logic               ctrl_input_stream_en,
    output logic               ctrl_acc_clear,
    output logic               ctrl_acc_last,
    output logic               ctrl_drain_en,
    output logic [TILE_W-1:0]  tile_n_idx,
    output logic [TILE_W-1:0]  tile_k_idx
);

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DMA_LAST  = CNT_W'(DMA_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(LATENCY - 1);

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] state_nxt_s;
    logic [CNT_W-1:0]   phase_r;
    logic [CNT_W-1:0]   seq_len_r;
    logic [TILE_W-1:0]  n_tiles_r;
    logic [TILE_W-1:0]  k_tiles_r;

    logic               latch_cfg_s;
    logic               idx_clear_s;
    logic               step_k_s;
    logic               step_n_s;
    logic               phase_inc_s;
    logic               cfg_zero_s;

    logic [TILE_W-1:0]  n_idx_s;
    logic [TILE_W-1:0]  k_idx_s;
    logic               k_last_s;
    logic               n_last_s;

    tile_loop_counter #(
        .TILE_W (TILE_W)
    ) u_tile_loop (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (idx_clear_s),
        .step_k (step_k_s),
        .step_n (step_n_s),
        .n_max  (n_tiles_r),
        .k_max  (k_tiles_r),
        .n_idx  (n_idx_s),
        .k_idx  (k_idx_s),
        .k_last (k_last_s),
        .n_last (n_last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic plus the loop/phase control strobes tied to transitions.
    always_comb begin
        state_nxt_s = state_r;
        latch_cfg_s = 1'b0;
        idx_clear_s = 1'b0;
        step_k_s    = 1'b0;
        step_n_s    = 1'b0;
        phase_inc_s = 1'b0;
        cfg_zero_s  = (cfg_seq_len == {CNT_W{1'b0}}) ||
                      (cfg_n_tiles == {TILE_W{1'b0}}) ||
                      (cfg_k_tiles == {TILE_W{1'b0}});
        if (ap_abort && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
            idx_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ap_start && !ap_abort) begin
                        latch_cfg_s = 1'b1;
                        idx_clear_s = 1'b1;
                        state_nxt_s = cfg_zero_s ? ST_DONE : ST_DMA_W;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DMA_W: begin
                    phase_inc_s = 1'b1;
                    if (phase_r == DMA_LAST) begin
                        state_nxt_s = ST_LOAD_W;
                    end else begin
                        state_nxt_s = ST_DMA_W;
                    end
                end
                ST_LOAD_W: begin
                    phase_inc_s = i_weight_valid;
                    if (i_weight_valid && (phase_r == LOAD_LAST)) begin
                        state_nxt_s = ST_COMPUTE;
                    end else begin
                        state_nxt_s = ST_LOAD_W;
                    end
                end
                ST_COMPUTE: begin
                    phase_inc_s = i_input_valid;
                    if (i_input_valid && (phase_r == (seq_len_r - CNT_ONE))) begin
                        if (k_last_s) begin
                            state_nxt_s = ST_DRAIN;
                        end else begin
                            step_k_s    = 1'b1;
                            state_nxt_s = ST_DMA_W;
                        end
                    end else begin
                        state_nxt_s = ST_COMPUTE;
                    end
                end
                ST_DRAIN: begin
                    phase_inc_s = 1'b1;
                    if (phase_r == LAT_LAST) begin
                        if (n_last_s) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            step_n_s    = 1'b1;
                            state_nxt_s = ST_DMA_W;
                        end
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Phase counter restarts on every state change so each phase counts from 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r <= {CNT_W{1'b0}};
        end else if ((state_nxt_s != state_r) || latch_cfg_s) begin
            phase_r <= {CNT_W{1'b0}};
        end else if (phase_inc_s) begin
            phase_r <= phase_r + CNT_ONE;
        end else begin
            phase_r <= phase_r;
        end
    end

    // Shadow config: captured once at start, immune to later cfg_* changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_len_r <= {CNT_W{1'b0}};
            n_tiles_r <= {TILE_W{1'b0}};
            k_tiles_r <= {TILE_W{1'b0}};
        end else if (latch_cfg_s) begin
            seq_len_r <= cfg_seq_len;
            n_tiles_r <= cfg_n_tiles;
            k_tiles_r <= cfg_k_tiles;
        end else begin
            seq_len_r <= seq_len_r;
            n_tiles_r <= n_tiles_r;
            k_tiles_r <= k_tiles_r;
        end
    end

    // Output decode of the registered state.
    always_comb begin
        ap_idle              = 1'b0;
        ap_done              = 1'b0;
        ctrl_weight_dma_req  = 1'b0;
        ctrl_weight_load_en  = 1'b0;
        ctrl_input_stream_en = 1'b0;
        ctrl_acc_clear       = 1'b0;
        ctrl_acc_last        = 1'b0;
        ctrl_drain_en        = 1'b0;
        case (state_r)
            ST_IDLE:    ap_idle             = 1'b1;
            ST_DMA_W:   ctrl_weight_dma_req = 1'b1;
            ST_LOAD_W:  ctrl_weight_load_en = 1'b1;
            ST_COMPUTE: begin
                ctrl_input_stream_en = 1'b1;
                ctrl_acc_clear       = (k_idx_s == {TILE_W{1'b0}});
                ctrl_acc_last        = k_last_s;
            end
            ST_DRAIN:   ctrl_drain_en       = 1'b1;
            ST_DONE:    ap_done             = 1'b1;
            default:    ap_idle             = 1'b0;
        endcase
    end

    assign state_dbg  = state_r;
    assign tile_n_idx = n_idx_s;
    assign tile_k_idx = k_idx_s;

endmodule

// File: tb/tb_tiled_gemm_controller.sv
// Scoreboard bench: stimulus pushes hand-derived per-state segments, a
// negedge monitor pops them and checks every output cycle by cycle.
module tb_tiled_gemm_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_abort = 1'b0;
    logic [31:0] cfg_seq_len = 32'd0;
    logic [15:0] cfg_n_tiles = 16'd0;
    logic [15:0] cfg_k_tiles = 16'd0;
    logic        ap_done, ap_idle;
    logic [2:0]  state_dbg;
    logic        ctrl_weight_dma_req, ctrl_weight_load_en, ctrl_input_stream_en;
    logic        ctrl_acc_clear, ctrl_acc_last, ctrl_drain_en;
    logic        i_weight_valid = 1'b1;
    logic        i_input_valid = 1'b1;
    logic [15:0] tile_n_idx, tile_k_idx;

    tiled_gemm_controller dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ap_start             (ap_start),
        .ap_abort             (ap_abort),
        .cfg_seq_len          (cfg_seq_len),
        .cfg_n_tiles          (cfg_n_tiles),
        .cfg_k_tiles          (cfg_k_tiles),
        .ap_done              (ap_done),
        .ap_idle              (ap_idle),
        .state_dbg            (state_dbg),
        .ctrl_weight_dma_req  (ctrl_weight_dma_req),
        .i_weight_valid       (i_weight_valid),
        .ctrl_weight_load_en  (ctrl_weight_load_en),
        .i_input_valid        (i_input_valid),
        .ctrl_input_stream_en (ctrl_input_stream_en),
        .ctrl_acc_clear       (ctrl_acc_clear),
        .ctrl_acc_last        (ctrl_acc_last),
        .ctrl_drain_en        (ctrl_drain_en),
        .tile_n_idx           (tile_n_idx),
        .tile_k_idx           (tile_k_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        int          len;
        logic        clr;
        logic        last;
        logic        chk;
        logic [15:0] n;
        logic [15:0] k;
    } seg_t;

    seg_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   left = 0;
    int   cur = 0;
    int   mode = 0;

    // Monitor: one segment cycle consumed per falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            seg_t s;
            logic [10:0] act, exp;
            s = sb_q[0];
            if (left == 0) left = s.len;
            act = {ap_idle, ap_done, state_dbg, ctrl_weight_dma_req, ctrl_weight_load_en,
                   ctrl_input_stream_en, ctrl_acc_clear, ctrl_acc_last, ctrl_drain_en};
            exp = {s.st == 3'd0, s.st == 3'd5, s.st, s.st == 3'd1, s.st == 3'd2,
                   s.st == 3'd3, s.clr, s.last, s.st == 3'd4};
            n_cmp++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL outputs t=%0t st=%0d: got %b expected %b", $time, s.st, act, exp);
            end
            if (s.chk) begin
                n_cmp++;
                if ({tile_n_idx, tile_k_idx} !== {s.n, s.k}) begin
                    n_fail++;
                    $display("FAIL indices t=%0t st=%0d: got n=%0d k=%0d expected n=%0d k=%0d",
                             $time, s.st, tile_n_idx, tile_k_idx, s.n, s.k);
                end
            end
            left--;
            if (left == 0) void'(sb_q.pop_front());
        end
    end

    task automatic push(input logic [2:0] st, input int len, input logic clr, input logic last,
                        input logic chk, input int n, input int k);
        seg_t s;
        s.st = st; s.len = len; s.clr = clr; s.last = last; s.chk = chk;
        s.n = 16'(n); s.k = 16'(k);
        sb_q.push_back(s);
    endtask

    // Full run with given LOAD_W / COMPUTE lengths per tile.
    task automatic push_run(input int nt, input int kt, input int load_len, input int comp_len);
        push(3'd0, 1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int n = 0; n < nt; n++) begin
            for (int k = 0; k < kt; k++) begin
                push(3'd1, 27, 1'b0, 1'b0, 1'b1, n, k);
                push(3'd2, load_len, 1'b0, 1'b0, 1'b1, n, k);
                push(3'd3, comp_len, k == 0, k == kt - 1, 1'b1, n, k);
            end
            push(3'd4, 28, 1'b0, 1'b0, 1'b1, n, kt - 1);
        end
        push(3'd5, 1, 1'b0, 1'b0, 1'b1, nt - 1, kt - 1);
        push(3'd0, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic apply_valids();
        if (mode == 1) begin
            i_weight_valid = !(cur >= 31 && cur <= 35);
            i_input_valid  = (cur < 45) ? 1'b1 : (((cur - 45) % 2) == 0);
        end else begin
            i_weight_valid = 1'b1;
            i_input_valid  = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cur++;
        ap_start = 1'b0;
        ap_abort = 1'b0;
        rst_n    = 1'b1;
        apply_valids();
    endtask

    task automatic goto_cycle(input int c);
        while (cur < c) step();
    endtask

    task automatic start_run(input int seq, input int nt, input int kt);
        @(posedge clk);
        #1;
        cur = 0;
        cfg_seq_len = 32'(seq);
        cfg_n_tiles = 16'(nt);
        cfg_k_tiles = 16'(kt);
        ap_start = 1'b1;
        apply_valids();
    endtask

    task automatic finish_bench();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    task automatic wait_done(input string name);
        int budget;
        budget = 2000;
        while (sb_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout %s: %0d segments left, expected 0", name, sb_q.size());
            finish_bench();
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        push(3'd0, 2, 1'b0, 1'b0, 1'b1, 0, 0);
        wait_done("reset");

        mode = 0;
        start_run(4, 1, 1);
        push_run(1, 1, 12, 4);
        wait_done("n1k1");

        start_run(2, 2, 3);
        push_run(2, 3, 12, 2);
        wait_done("n2k3");

        mode = 1;
        start_run(8, 1, 1);
        push_run(1, 1, 17, 15);
        wait_done("stall");
        mode = 0;

        start_run(4, 1, 0);
        push(3'd0, 1, 1'b0, 1'b0, 1'b0, 0, 0);
        push(3'd5, 1, 1'b0, 1'b0, 1'b1, 0, 0);
        push(3'd0, 1, 1'b0, 1'b0, 1'b0, 0, 0);
        wait_done("zero_k");

        start_run(4, 2, 1);
        push(3'd0, 1, 1'b0, 1'b0, 1'b0, 0, 0);
        push(3'd1, 27, 1'b0, 1'b0, 1'b1, 0, 0);
        push(3'd2, 12, 1'b0, 1'b0, 1'b1, 0, 0);
        push(3'd3, 4, 1'b1, 1'b1, 1'b1, 0, 0);
        push(3'd4, 28, 1'b0, 1'b0, 1'b1, 0, 0);
        push(3'd1, 27, 1'b0, 1'b0, 1'b1, 1, 0);
        push(3'd2, 12, 1'b0, 1'b0, 1'b1, 1, 0);
        push(3'd3, 2, 1'b1, 1'b1, 1'b1, 1, 0);
        push(3'd0, 2, 1'b0, 1'b0, 1'b1, 0, 0);
        goto_cycle(112);
        ap_abort = 1'b1;
        wait_done("abort");

        start_run(4, 1, 1);
        push_run(1, 1, 12, 4);
        wait_done("after_abort");

        start_run(3, 1, 2);
        push(3'd0, 1, 1'b0, 1'b0, 1'b0, 0, 0);
        push(3'd1, 27, 1'b0, 1'b0, 1'b1, 0, 0);
        push(3'd2, 12, 1'b0, 1'b0, 1'b1, 0, 0);
        push(3'd3, 3, 1'b1, 1'b0, 1'b1, 0, 0);
        push(3'd1, 27, 1'b0, 1'b0, 1'b1, 0, 1);
        push(3'd2, 12, 1'b0, 1'b0, 1'b1, 0, 1);
        push(3'd3, 3, 1'b0, 1'b1, 1'b1, 0, 1);
        push(3'd4, 6, 1'b0, 1'b0, 1'b1, 0, 1);
        push(3'd0, 2, 1'b0, 1'b0, 1'b1, 0, 0);
        goto_cycle(5);
        cfg_seq_len = 32'd9;
        cfg_n_tiles = 16'd7;
        cfg_k_tiles = 16'd5;
        goto_cycle(90);
        rst_n = 1'b0;
        wait_done("reset_in_drain");

        finish_bench();
    end

endmodule
